// File: rtl/register_unload_serializer_pkg.sv
// Shared types and helpers for the register unload serializer and its companion blocks.
package register_unload_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to hold values 0..n, i.e. $clog2(n+1) with a floor of 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < (n + 32'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/register_unload_serializer_if.sv
// Load handshake and serial output handshake bundle for the unload serializer.
interface register_unload_serializer_if #(
    parameter int unsigned N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, out_bit, out_last, busy
    );

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/register_unload_serializer_serial_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module serial_bit_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    // Load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/register_unload_serializer.sv
// Parallel-to-serial unload: captures an N-bit word and emits it MSB first, one bit per handshake.
// Optional SER_PARITY_EN appends an even-parity beat after the data bits.
module register_unload_serializer
    import register_unload_serializer_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input logic                          clk,
    input logic                          rst,
    register_unload_serializer_if.slave  s
);
    localparam int unsigned CW = cnt_width(N);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] LOAD_VAL = CW'(N);
`else
    localparam logic [CW-1:0] LOAD_VAL = CW'(N - 1);
`endif

    state_t       r_state;
    logic [N-1:0] r_shreg;
    logic         w_load;
    logic         w_fire;
    logic         w_cnt_zero;
    logic         w_shift_bit;
    logic         w_in_shift;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_load     = (r_state == ST_IDLE) && s.in_valid;
    assign w_fire     = w_in_shift && s.out_ready;

    serial_bit_counter #(.W(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_fire && !w_cnt_zero),
        .o_zero     (w_cnt_zero)
    );

`ifdef SER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^s.D;
        end
    end

    // Counter reaches zero only on the trailing parity beat.
    assign w_shift_bit = w_cnt_zero ? r_par : r_shreg[N-1];
`else
    assign w_shift_bit = r_shreg[N-1];
`endif

    // Frame FSM and shift register; the shift register only moves on an accepted non-final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s.in_valid) begin
                        r_shreg <= s.D;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (s.out_ready) begin
                        if (w_cnt_zero) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_shreg <= r_shreg << 1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s.in_ready  = (r_state == ST_IDLE);
    assign s.busy      = w_in_shift;
    assign s.out_valid = w_in_shift;
    assign s.out_bit   = w_in_shift && w_shift_bit;
    assign s.out_last  = w_in_shift && w_cnt_zero;
endmodule

// File: tb/tb_register_unload_serializer.sv
// Randomized and directed bench for register_unload_serializer against a beat-list reference model.
module tb_register_unload_serializer;
    localparam int unsigned N = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    register_unload_serializer_if #(.N(N)) ser_if ();

    register_unload_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .s   (ser_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  ser_if.in_ready,  1'b1);
        chk({tag, "_out_valid"}, ser_if.out_valid, 1'b0);
        chk({tag, "_busy"},      ser_if.busy,      1'b0);
        chk({tag, "_out_bit"},   ser_if.out_bit,   1'b0);
        chk({tag, "_out_last"},  ser_if.out_last,  1'b0);
    endtask

    // Loads d, then walks the expected beat list (MSB first, optional parity) under backpressure.
    // stall_beat >= 0 stalls exactly that beat for stall_len cycles; otherwise stalls are random.
    task automatic run_frame(input logic [N-1:0] d, input int stall_pct,
                             input int stall_beat, input int stall_len,
                             input logic hold_next, input logic [N-1:0] next_d);
        bit q[$];
        int b;
        int stalls;
        int budget;
        logic rdy;
        for (int i = N - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SER_PARITY_EN
        q.push_back(^d);
`endif
        chk("load_in_ready", ser_if.in_ready, 1'b1);
        ser_if.in_valid  = 1'b1;
        ser_if.D         = d;
        ser_if.out_ready = 1'b0;
        tick();
        ser_if.in_valid = hold_next;
        ser_if.D        = hold_next ? next_d : '0;
        b      = 0;
        stalls = 0;
        budget = 0;
        while (b < q.size() && budget < 200) begin
            budget++;
            chk("beat_valid",    ser_if.out_valid, 1'b1);
            chk("beat_bit",      ser_if.out_bit,   q[b]);
            chk("beat_last",     ser_if.out_last,  (b == q.size() - 1));
            chk("beat_in_ready", ser_if.in_ready,  1'b0);
            chk("beat_busy",     ser_if.busy,      1'b1);
            if (stall_beat >= 0)
                rdy = !((b == stall_beat) && (stalls < stall_len));
            else
                rdy = (stalls >= 6) || ($urandom_range(99) >= stall_pct);
            ser_if.out_ready = rdy;
            tick();
            if (rdy) begin
                b++;
                stalls = 0;
            end else begin
                stalls++;
            end
        end
        chk("frame_completed", (b == q.size()), 1'b1);
        ser_if.out_ready = 1'b0;
        chk("post_in_ready",  ser_if.in_ready,  1'b1);
        chk("post_out_valid", ser_if.out_valid, 1'b0);
        chk("post_busy",      ser_if.busy,      1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ser_if.in_valid  = 1'b0;
        ser_if.D         = '0;
        ser_if.out_ready = 1'b0;

        // Reset with a pending load: nothing may be captured.
        rst = 1'b1;
        ser_if.in_valid = 1'b1;
        ser_if.D        = 3'b111;
        tick();
        tick();
        chk_idle("reset");
        ser_if.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk_idle("after_reset");

        // Basic frame with no backpressure.
        run_frame(3'b110, 0, -1, 0, 1'b0, '0);

        // Stall the second beat for two cycles.
        run_frame(3'b101, 0, 1, 2, 1'b0, '0);

        // Load held during a frame is taken only once the block returns to idle.
        run_frame(3'b110, 0, -1, 0, 1'b1, 3'b011);
        run_frame(3'b011, 0, -1, 0, 1'b0, '0);

        // Reset after the first accepted bit aborts the frame.
        ser_if.in_valid  = 1'b1;
        ser_if.D         = 3'b111;
        tick();
        ser_if.in_valid  = 1'b0;
        chk("abort_first_bit", ser_if.out_bit, 1'b1);
        ser_if.out_ready = 1'b1;
        tick();
        chk("abort_second_valid", ser_if.out_valid, 1'b1);
        ser_if.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        run_frame(3'b010, 0, -1, 0, 1'b0, '0);

        // Parity-specific word from the directed plan; plain data otherwise.
        run_frame(3'b100, 0, -1, 0, 1'b0, '0);

        // Random words under random backpressure, with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] w;
            int gap;
            w   = N'($urandom);
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_idle_valid", ser_if.out_valid, 1'b0);
            end
            run_frame(w, 35, -1, 0, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
